// File: rtl/flash_fill.sv
// flash_fill: copies the main region from flash into main SRAM after reset, then
// services read misses by fetching one aligned SUB_DEPTH-word block into sub-SRAM.
module flash_fill #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           SUB_DEPTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] MAIN_LOWER = ADDR_WIDTH'(32'h0000_0000),
    parameter logic [ADDR_WIDTH-1:0] MAIN_UPPER = ADDR_WIDTH'(32'h0000_0400)
) (
    input  logic                  clk,
    input  logic                  grst,
    input  logic                  miss_vld,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    output logic                  miss_rdy,
    output logic                  flash_req,
    output logic [ADDR_WIDTH-1:0] flash_addr,
    input  logic                  flash_gnt,
    input  logic                  flash_vld,
    input  logic [DATA_WIDTH-1:0] flash_data,
    output logic                  wr_en,
    output logic                  wr_main,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  preload_done,
    output logic                  fill_done,
    output logic                  miss_err
);

    typedef enum logic [2:0] {
        PRELOAD_REQ,
        PRELOAD_WAIT,
        IDLE,
        FILL_REQ,
        FILL_WAIT
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(SUB_DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  req_q, req_d;
    logic                  wr_en_q, wr_en_d;
    logic                  wr_main_q, wr_main_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  pre_done_q, pre_done_d;
    logic                  fill_done_q, fill_done_d;
    logic                  miss_err_q, miss_err_d;

    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] cnt_inc;
    logic                  accept;
    logic                  in_main;
    logic                  blk_last;
    logic                  gnt_taken;

    assign miss_rdy  = (state_q == IDLE) && !fill_done_q;
    assign accept    = miss_vld && miss_rdy;
    assign base      = miss_addr & ~OFF_MASK;
    // Unsigned range test [LOWER, UPPER) via offset from LOWER; avoids a constant compare when LOWER is 0.
    assign in_main   = (base - MAIN_LOWER) < (MAIN_UPPER - MAIN_LOWER);
    assign cnt_inc   = cnt_q + ADDR_WIDTH'(1);
    assign blk_last  = (cnt_q & OFF_MASK) == OFF_MASK;
    assign gnt_taken = req_q && flash_gnt;

    assign flash_req    = req_q;
    assign flash_addr   = req_q ? cnt_q : '0;
    assign wr_en        = wr_en_q;
    assign wr_main      = wr_main_q;
    assign waddr        = waddr_q;
    assign wdata        = wdata_q;
    assign preload_done = pre_done_q;
    assign fill_done    = fill_done_q;
    assign miss_err     = miss_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = 1'b0;
        wr_en_d     = 1'b0;
        wr_main_d   = wr_main_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        pre_done_d  = pre_done_q;
        fill_done_d = 1'b0;
        miss_err_d  = 1'b0;
        case (state_q)
            PRELOAD_REQ: begin
                if (gnt_taken) state_d = PRELOAD_WAIT;
                else           req_d   = 1'b1;
            end
            PRELOAD_WAIT: begin
                if (flash_vld) begin
                    wr_en_d   = 1'b1;
                    wr_main_d = 1'b1;
                    waddr_d   = cnt_q;
                    wdata_d   = flash_data;
                    cnt_d     = cnt_inc;
                    if (cnt_inc == MAIN_UPPER) begin
                        pre_done_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        state_d = PRELOAD_REQ;
                        req_d   = 1'b1;
                    end
                end
            end
            IDLE: begin
                if (accept) begin
                    if (in_main) begin
                        miss_err_d = 1'b1;
                    end else begin
                        cnt_d   = base;
                        state_d = FILL_REQ;
                        req_d   = 1'b1;
                    end
                end
            end
            FILL_REQ: begin
                if (gnt_taken) state_d = FILL_WAIT;
                else           req_d   = 1'b1;
            end
            FILL_WAIT: begin
                if (flash_vld) begin
                    wr_en_d   = 1'b1;
                    wr_main_d = 1'b0;
                    waddr_d   = cnt_q;
                    wdata_d   = flash_data;
                    cnt_d     = cnt_inc;
                    if (blk_last) begin
                        fill_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = FILL_REQ;
                        req_d   = 1'b1;
                    end
                end
            end
            default: state_d = PRELOAD_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            state_q     <= PRELOAD_REQ;
            cnt_q       <= MAIN_LOWER;
            req_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_main_q   <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            pre_done_q  <= 1'b0;
            fill_done_q <= 1'b0;
            miss_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            wr_en_q     <= wr_en_d;
            wr_main_q   <= wr_main_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            pre_done_q  <= pre_done_d;
            fill_done_q <= fill_done_d;
            miss_err_q  <= miss_err_d;
        end
    end

endmodule

// File: tb/tb_flash_fill.sv
// Scoreboard bench for flash_fill: a flash responder model, a write/read expectation
// queue filled on stimulus, and a monitor that checks every DUT output cycle.
module tb_flash_fill;

    localparam int unsigned SUB   = 4;
    localparam longint      LOWER = 0;
    localparam longint      UPPER = 8;

    typedef struct {
        logic        main;
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } wr_t;

    logic        clk = 1'b0;
    logic        grst = 1'b1;
    logic        miss_vld = 1'b0;
    logic [31:0] miss_addr = '0;
    logic        miss_rdy;
    logic        flash_req;
    logic [31:0] flash_addr;
    logic        flash_gnt = 1'b0;
    logic        flash_vld = 1'b0;
    logic [31:0] flash_data = '0;
    logic        wr_en, wr_main, preload_done, fill_done, miss_err;
    logic [31:0] waddr, wdata;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    wr_t         exp_w[$];
    logic [31:0] exp_r[$];
    logic        err_pending = 1'b0;
    logic        preload_exp = 1'b0;
    int unsigned sub_wr_cnt = 0;
    int unsigned stall = 0;
    int unsigned lat = 2;
    logic        spurious_en = 1'b0;

    flash_fill #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .SUB_DEPTH (4),
        .MAIN_LOWER(32'h0000_0000),
        .MAIN_UPPER(32'h0000_0008)
    ) dut (
        .clk         (clk),
        .grst        (grst),
        .miss_vld    (miss_vld),
        .miss_addr   (miss_addr),
        .miss_rdy    (miss_rdy),
        .flash_req   (flash_req),
        .flash_addr  (flash_addr),
        .flash_gnt   (flash_gnt),
        .flash_vld   (flash_vld),
        .flash_data  (flash_data),
        .wr_en       (wr_en),
        .wr_main     (wr_main),
        .waddr       (waddr),
        .wdata       (wdata),
        .preload_done(preload_done),
        .fill_done   (fill_done),
        .miss_err    (miss_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fdata(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h expected nothing at %0t", name, act, $time);
    endtask

    task automatic push_preload();
        wr_t e;
        for (int i = 0; i < UPPER; i++) begin
            e.main = 1'b1;
            e.addr = 32'(i);
            e.data = fdata(32'(i));
            e.last = (i == UPPER - 1);
            exp_w.push_back(e);
            exp_r.push_back(32'(i));
        end
    endtask

    task automatic model_accept(input logic [31:0] a);
        logic [31:0] base;
        wr_t         e;
        base = a & ~32'(SUB - 1);
        if (longint'(base) >= LOWER && longint'(base) < UPPER) begin
            err_pending = 1'b1;
        end else begin
            for (int i = 0; i < SUB; i++) begin
                e.main = 1'b0;
                e.addr = base + 32'(i);
                e.data = fdata(e.addr);
                e.last = (i == SUB - 1);
                exp_w.push_back(e);
                exp_r.push_back(e.addr);
            end
        end
    endtask

    task automatic issue_miss(input logic [31:0] a);
        int unsigned t = 0;
        @(negedge clk);
        miss_vld  = 1'b1;
        miss_addr = a;
        while (!miss_rdy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!miss_rdy) begin
            note_fail("miss_accept_timeout", a);
            miss_vld = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            miss_vld  = 1'b0;
            miss_addr = $urandom;
            model_accept(a);
        end
    endtask

    task automatic wait_drain();
        int unsigned t = 0;
        while ((exp_w.size() != 0 || exp_r.size() != 0 || err_pending) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (exp_w.size() != 0 || exp_r.size() != 0 || err_pending)
            note_fail("drain_timeout", 64'(exp_w.size()));
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_flash_req"}, flash_req, 0);
        chk({tag, "_flash_addr"}, flash_addr, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_main"}, wr_main, 0);
        chk({tag, "_waddr"}, waddr, 0);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_preload_done"}, preload_done, 0);
        chk({tag, "_fill_done"}, fill_done, 0);
        chk({tag, "_miss_err"}, miss_err, 0);
        chk({tag, "_miss_rdy"}, miss_rdy, 0);
    endtask

    initial begin : flash_model
        int unsigned lat_cnt = 0;
        logic        outstanding = 1'b0;
        logic        waiting = 1'b0;
        logic [31:0] held_addr = '0;
        logic [31:0] g_addr = '0;
        forever begin
            @(negedge clk);
            if (grst) begin
                flash_gnt   = 1'b0;
                flash_vld   = 1'b0;
                outstanding = 1'b0;
                waiting     = 1'b0;
            end else begin
                flash_vld = 1'b0;
                if (outstanding) begin
                    if (lat_cnt <= 1) begin
                        flash_vld   = 1'b1;
                        flash_data  = fdata(g_addr);
                        outstanding = 1'b0;
                    end else begin
                        lat_cnt--;
                    end
                end else if (spurious_en && $urandom_range(0, 7) == 0) begin
                    flash_vld  = 1'b1;
                    flash_data = $urandom;
                end
                if (waiting) begin
                    chk("req_held", flash_req, 1);
                    chk("addr_held", flash_addr, held_addr);
                end
                flash_gnt = 1'b0;
                waiting   = 1'b0;
                if (flash_req) begin
                    chk("one_outstanding", outstanding, 0);
                    if (stall > 0) begin
                        stall--;
                        waiting   = 1'b1;
                        held_addr = flash_addr;
                    end else begin
                        flash_gnt = 1'b1;
                        if (exp_r.size() == 0) note_fail("unexpected_read", flash_addr);
                        else chk("read_addr", flash_addr, exp_r.pop_front());
                        outstanding = 1'b1;
                        lat_cnt     = lat;
                        g_addr      = flash_addr;
                    end
                end
            end
        end
    end

    initial begin : monitor
        wr_t  e;
        logic last_sub;
        forever begin
            @(negedge clk);
            if (!grst) begin
                last_sub = 1'b0;
                if (wr_en) begin
                    if (exp_w.size() == 0) begin
                        note_fail("unexpected_write", waddr);
                    end else begin
                        e = exp_w.pop_front();
                        chk("waddr", waddr, e.addr);
                        chk("wdata", wdata, e.data);
                        chk("wr_main", wr_main, e.main);
                        chk("fill_done", fill_done, e.last && !e.main);
                        if (e.main && e.last) preload_exp = 1'b1;
                        chk("preload_done", preload_done, preload_exp);
                        last_sub = e.last && !e.main;
                        if (!e.main) sub_wr_cnt++;
                    end
                end else if (fill_done) begin
                    note_fail("fill_done_without_write", fill_done);
                end
                chk("miss_rdy", miss_rdy, (exp_w.size() == 0) && !last_sub);
                if (miss_err || err_pending) begin
                    chk("miss_err", miss_err, err_pending);
                    err_pending = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int unsigned start;
        int unsigned t;
        logic [31:0] a;
        push_preload();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        grst = 1'b0;

        // preload, then a fill at 0x13 with 2-cycle latency
        wait_drain();
        chk("preload_done_level", preload_done, 1);
        issue_miss(32'h0000_0013);
        wait_drain();

        // main-region miss must not touch flash
        issue_miss(32'h0000_0005);
        repeat (5) begin
            @(negedge clk);
            chk("err_no_req", flash_req, 0);
            chk("err_idle_rdy", miss_rdy, 1);
        end
        wait_drain();

        // grant back-pressure plus a miss held across a running fill
        stall = 5;
        issue_miss(32'h0000_0040);
        issue_miss(32'h0000_0083);
        wait_drain();

        issue_miss(32'hFFFF_FFFE);
        wait_drain();

        spurious_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            lat   = $urandom_range(1, 3);
            stall = $urandom_range(0, 3);
            case ($urandom_range(0, 7))
                0, 1:    a = $urandom_range(0, 7);
                2:       a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: a = $urandom;
            endcase
            issue_miss(a);
            if ($urandom_range(0, 1) == 0) wait_drain();
        end
        spurious_en = 1'b0;
        wait_drain();

        // asynchronous reset after the second write of a fill
        lat   = 2;
        stall = 0;
        start = sub_wr_cnt;
        issue_miss(32'h0000_0100);
        t = 0;
        while (sub_wr_cnt < start + 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sub_wr_cnt < start + 2) note_fail("second_write_timeout", 64'(sub_wr_cnt - start));
        #2;
        grst = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        exp_w.delete();
        exp_r.delete();
        err_pending = 1'b0;
        preload_exp = 1'b0;
        push_preload();
        repeat (3) @(negedge clk);
        grst = 1'b0;
        wait_drain();
        chk("preload_done_after_reset", preload_done, 1);
        issue_miss(32'h0000_002C);
        wait_drain();

        repeat (4) @(negedge clk);
        chk("final_write_queue", exp_w.size(), 0);
        chk("final_read_queue", exp_r.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
